cursor_overlay: RTL

//  Parametrised successor to the single bouncing-XOR cursor: overlays NUM_CURSORS rectangular

---
 rtl/cursor_overlay_pkg.sv | 28 ++
 rtl/cursor_overlay_hit.sv | 27 ++
 rtl/cursor_overlay.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_overlay_pkg.sv
// Shared definitions for the cursor overlay: video timing defaults, cursor
// blend-mode encodings, register offsets and the frame-update FSM states.
package cursor_overlay_pkg;

  localparam int H_ACTIVE_DEF = 1920;
  localparam int V_ACTIVE_DEF = 1080;

  localparam int H_W   = 12;
  localparam int V_W   = 11;
  localparam int PIX_W = 24;

  localparam logic [1:0] CUR_OFF   = 2'd0;
  localparam logic [1:0] CUR_XOR   = 2'd1;
  localparam logic [1:0] CUR_SOLID = 2'd2;
  localparam logic [1:0] CUR_INV   = 2'd3;

  localparam logic [1:0] REG_XPOS   = 2'd0;
  localparam logic [1:0] REG_YPOS   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COLOUR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_BOUNCE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/cursor_overlay_hit.sv
// Per-cursor rectangle comparator: hit when (h, v) lies inside
// [x, x+size_x) x [y, y+size_y). Sums are one bit wider so they never wrap;
// a zero size yields an empty range and therefore never hits.
module cursor_overlay_hit
  import cursor_overlay_pkg::*;
#(
  parameter int SIZE_W = 8
) (
  input  logic [H_W-1:0]    x_pos,
  input  logic [V_W-1:0]    y_pos,
  input  logic [SIZE_W-1:0] size_x,
  input  logic [SIZE_W-1:0] size_y,
  input  logic [H_W-1:0]    h,
  input  logic [V_W-1:0]    v,
  output logic              hit
);

  logic [H_W:0] x_end;
  logic [V_W:0] y_end;

  assign x_end = {1'b0, x_pos} + (H_W+1)'(size_x);
  assign y_end = {1'b0, y_pos} + (V_W+1)'(size_y);

  assign hit = (h >= x_pos) && ({1'b0, h} < x_end) &&
               (v >= y_pos) && ({1'b0, v} < y_end);

endmodule

// File: rtl/cursor_overlay.sv
// Multi-cursor overlay on a 24-bit pixel stream, two-cycle latency.
// Config writes land in shadow registers and are committed at frame start.
// Optional feature macro: CURSOR_OVERLAY_BOUNCE_EN enables hardware bounce
// animation of cursors whose bounce bit is set.
module cursor_overlay
  import cursor_overlay_pkg::*;
#(
  parameter int NUM_CURSORS = 4,
  parameter int SIZE_W      = 8,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
  input  logic             vo_clk,
  input  logic             vo_reset_,
  input  logic             in_vsync,
  input  logic             in_req,
  input  logic             in_eol,
  input  logic             in_eof,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             cfg_wr,
  input  logic [4:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             out_vsync,
  output logic             out_req,
  output logic             out_eol,
  output logic             out_eof,
  output logic [PIX_W-1:0] out_pixel,
  output logic             frame_busy
);

  logic [NUM_CURSORS-1:0][H_W-1:0]    sh_x, ac_x;
  logic [NUM_CURSORS-1:0][V_W-1:0]    sh_y, ac_y;
  logic [NUM_CURSORS-1:0][1:0]        sh_mode, ac_mode;
  logic [NUM_CURSORS-1:0][SIZE_W-1:0] sh_sx, sh_sy, ac_sx, ac_sy;
  logic [NUM_CURSORS-1:0][PIX_W-1:0]  sh_col, ac_col;
  logic [NUM_CURSORS-1:0][3:0]        dirty;
`ifdef CURSOR_OVERLAY_BOUNCE_EN
  logic [NUM_CURSORS-1:0] sh_bnc, ac_bnc, dir_x, dir_y;
  logic [2:0]             bnc_idx, bnc_idx_nxt;
`endif

  fsm_state_e     state, state_nxt;
  logic           commit_en;
  logic [2:0]     wr_idx;
  logic [1:0]     wr_reg;
  logic           wr_ok;
  logic [H_W-1:0] h_cntr;
  logic [V_W-1:0] v_cntr;
  logic           unused_cfg;

  logic [NUM_CURSORS-1:0] hit_raw, hit_vec;

  logic                   vsync_p1, vld_p1, eol_p1, eof_p1;
  logic [PIX_W-1:0]       pixel_p1;
  logic [NUM_CURSORS-1:0] hit_p1;
  logic [1:0]             sel_mode;
  logic [PIX_W-1:0]       sel_col;

  function automatic logic [PIX_W-1:0] blend_px(input logic [1:0] mode,
                                                input logic [PIX_W-1:0] px,
                                                input logic [PIX_W-1:0] col);
    case (mode)
      CUR_XOR:   return px ^ {PIX_W{1'b1}};
      CUR_SOLID: return col;
      CUR_INV:   return px ^ col;
      default:   return px;
    endcase
  endfunction

  assign wr_idx     = cfg_addr[4:2];
  assign wr_reg     = cfg_addr[1:0];
  assign wr_ok      = cfg_wr && (int'(wr_idx) < NUM_CURSORS);
  assign commit_en  = (state == ST_COMMIT);
  assign frame_busy = (state != ST_IDLE);

`ifdef CURSOR_OVERLAY_BOUNCE_EN
  assign unused_cfg = ^cfg_wdata[31:24];
`else
  assign unused_cfg = ^{cfg_wdata[31:24], H_ACTIVE[0], V_ACTIVE[0]};
`endif

  // Shadow registers take config writes; a write beats the commit-time dirty clear.
  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      sh_x    <= '0;
      sh_y    <= '0;
      sh_mode <= '0;
      sh_sx   <= '0;
      sh_sy   <= '0;
      sh_col  <= '0;
      dirty   <= '0;
`ifdef CURSOR_OVERLAY_BOUNCE_EN
      sh_bnc  <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CURSORS; i++) begin
        if (commit_en) dirty[i] <= 4'b0;
        if (wr_ok && int'(wr_idx) == i) begin
          dirty[i][wr_reg] <= 1'b1;
          case (wr_reg)
            REG_XPOS:   sh_x[i] <= cfg_wdata[H_W-1:0];
            REG_YPOS:   sh_y[i] <= cfg_wdata[V_W-1:0];
            REG_CTRL: begin
              sh_sx[i]   <= cfg_wdata[SIZE_W-1:0];
              sh_sy[i]   <= cfg_wdata[8 +: SIZE_W];
              sh_mode[i] <= cfg_wdata[17:16];
`ifdef CURSOR_OVERLAY_BOUNCE_EN
              sh_bnc[i]  <= cfg_wdata[18];
`endif
            end
            REG_COLOUR: sh_col[i] <= cfg_wdata[PIX_W-1:0];
          endcase
        end
      end
    end
  end

  // Active registers: dirty shadows copied on commit, positions stepped during bounce.
  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      ac_x    <= '0;
      ac_y    <= '0;
      ac_mode <= '0;
      ac_sx   <= '0;
      ac_sy   <= '0;
      ac_col  <= '0;
`ifdef CURSOR_OVERLAY_BOUNCE_EN
      ac_bnc  <= '0;
      dir_x   <= '0;
      dir_y   <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CURSORS; i++) begin
        if (commit_en) begin
          if (dirty[i][REG_XPOS]) ac_x[i] <= sh_x[i];
          if (dirty[i][REG_YPOS]) ac_y[i] <= sh_y[i];
          if (dirty[i][REG_CTRL]) begin
            ac_sx[i]   <= sh_sx[i];
            ac_sy[i]   <= sh_sy[i];
            ac_mode[i] <= sh_mode[i];
`ifdef CURSOR_OVERLAY_BOUNCE_EN
            ac_bnc[i]  <= sh_bnc[i];
`endif
          end
          if (dirty[i][REG_COLOUR]) ac_col[i] <= sh_col[i];
        end
`ifdef CURSOR_OVERLAY_BOUNCE_EN
        else if (state == ST_BOUNCE && int'(bnc_idx) == i && ac_bnc[i]) begin
          if (!dir_x[i]) begin
            if (({1'b0, ac_x[i]} + (H_W+1)'(ac_sx[i])) < (H_W+1)'(H_ACTIVE - 1))
              ac_x[i] <= ac_x[i] + H_W'(1);
            else
              dir_x[i] <= 1'b1;
          end else begin
            if (ac_x[i] != '0) ac_x[i] <= ac_x[i] - H_W'(1);
            else               dir_x[i] <= 1'b0;
          end
          if (!dir_y[i]) begin
            if (({1'b0, ac_y[i]} + (V_W+1)'(ac_sy[i])) < (V_W+1)'(V_ACTIVE - 1))
              ac_y[i] <= ac_y[i] + V_W'(1);
            else
              dir_y[i] <= 1'b1;
          end else begin
            if (ac_y[i] != '0) ac_y[i] <= ac_y[i] - V_W'(1);
            else               dir_y[i] <= 1'b0;
          end
        end
`endif
      end
    end
  end

  // Frame-update FSM state register.
  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      state   <= ST_IDLE;
`ifdef CURSOR_OVERLAY_BOUNCE_EN
      bnc_idx <= '0;
`endif
    end else begin
      state   <= state_nxt;
`ifdef CURSOR_OVERLAY_BOUNCE_EN
      bnc_idx <= bnc_idx_nxt;
`endif
    end
  end

  // Next state: vsync starts a commit only from IDLE; bounce walks every cursor once.
  always_comb begin
    state_nxt   = state;
`ifdef CURSOR_OVERLAY_BOUNCE_EN
    bnc_idx_nxt = bnc_idx;
`endif
    case (state)
      ST_IDLE: if (in_vsync) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
`ifdef CURSOR_OVERLAY_BOUNCE_EN
        state_nxt   = ST_BOUNCE;
        bnc_idx_nxt = '0;
`else
        state_nxt   = ST_IDLE;
`endif
      end
`ifdef CURSOR_OVERLAY_BOUNCE_EN
      ST_BOUNCE: begin
        if (int'(bnc_idx) == NUM_CURSORS - 1) state_nxt = ST_IDLE;
        else                                  bnc_idx_nxt = bnc_idx + 3'd1;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Raster position of the pixel currently on the input.
  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      h_cntr <= '0;
      v_cntr <= '0;
    end else begin
      if (in_req) begin
        if (in_eol) h_cntr <= '0;
        else        h_cntr <= h_cntr + H_W'(1);
        if (in_eof)      v_cntr <= '0;
        else if (in_eol) v_cntr <= v_cntr + V_W'(1);
      end
      if (in_vsync) v_cntr <= '0;
    end
  end

  for (genvar g = 0; g < NUM_CURSORS; g++) begin : g_hit
    cursor_overlay_hit #(.SIZE_W(SIZE_W)) u_hit (
      .x_pos  (ac_x[g]),
      .y_pos  (ac_y[g]),
      .size_x (ac_sx[g]),
      .size_y (ac_sy[g]),
      .h      (h_cntr),
      .v      (v_cntr),
      .hit    (hit_raw[g])
    );
    assign hit_vec[g] = hit_raw[g] && (ac_mode[g] != CUR_OFF);
  end

  // ---- stage 1: register stream and per-cursor hit vector ----
  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      eol_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      pixel_p1 <= '0;
      hit_p1   <= '0;
    end else begin
      vsync_p1 <= in_vsync;
      vld_p1   <= in_req;
      eol_p1   <= in_eol;
      eof_p1   <= in_eof;
      pixel_p1 <= in_pixel;
      hit_p1   <= hit_vec;
    end
  end

  // Priority select: the lowest-index hitting cursor wins.
  always_comb begin
    sel_mode = CUR_OFF;
    sel_col  = '0;
    for (int i = NUM_CURSORS - 1; i >= 0; i--) begin
      if (hit_p1[i]) begin
        sel_mode = ac_mode[i];
        sel_col  = ac_col[i];
      end
    end
  end

  // ---- stage 2: blend and drive outputs ----
  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      out_vsync <= 1'b0;
      out_req   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_vsync <= vsync_p1;
      out_req   <= vld_p1;
      out_eol   <= eol_p1;
      out_eof   <= eof_p1;
      out_pixel <= vld_p1 ? blend_px(sel_mode, pixel_p1, sel_col) : pixel_p1;
    end
  end

endmodule
